// File: rtl/life_manager_if.sv
// Life manager bus: game events in, life/status outputs back.
interface life_manager_if;
    localparam int unsigned CNT_W = 3;

    logic             i_new_game;
    logic             i_life_loss;
    logic             i_bonus_life;
    logic             i_frame_tick;
    logic [CNT_W-1:0] o_life_count;
    logic             o_invuln;
    logic             o_life_lost;
    logic             o_game_over;

    // Driver side (game logic / testbench)
    modport master (
        output i_new_game, i_life_loss, i_bonus_life, i_frame_tick,
        input  o_life_count, o_invuln, o_life_lost, o_game_over
    );

    // Life manager side
    modport slave (
        input  i_new_game, i_life_loss, i_bonus_life, i_frame_tick,
        output o_life_count, o_invuln, o_life_lost, o_game_over
    );
endinterface

// File: rtl/life_manager.sv
// Life manager: tracks remaining lives, post-loss invulnerability window and game-over.
module life_manager #(
    parameter int unsigned INIT_LIVES   = 3,
    parameter int unsigned MAX_LIVES    = 5,
    parameter int unsigned GRACE_FRAMES = 60
) (
    input  logic              i_clk,
    input  logic              i_rst,
    life_manager_if.slave     bus
);
    localparam int unsigned CNT_W   = 3;
    localparam int unsigned GRACE_W = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_GRACE = 2'd2,
        S_DEAD  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_nxt;
    logic [CNT_W-1:0]   w_count_inc;
    logic [GRACE_W-1:0] r_grace;
    logic [GRACE_W-1:0] w_grace_nxt;
    logic               w_life_lost_nxt;
    logic               r_life_lost;
    logic               r_invuln;
    logic               r_game_over;

    // Saturating bonus increment
    always_comb begin
        w_count_inc = r_count + CNT_W'(1);
        if (r_count >= CNT_W'(MAX_LIVES)) begin
            w_count_inc = CNT_W'(MAX_LIVES);
        end
    end

    // Next-state and next-value logic
    always_comb begin
        w_state_nxt     = r_state;
        w_count_nxt     = r_count;
        w_grace_nxt     = r_grace;
        w_life_lost_nxt = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (bus.i_new_game) begin
                    w_count_nxt = CNT_W'(INIT_LIVES);
                    w_state_nxt = S_PLAY;
                end
            end

            S_PLAY: begin
                if (bus.i_life_loss) begin
                    w_life_lost_nxt = 1'b1;
                    if (bus.i_bonus_life || (r_count > CNT_W'(1))) begin
                        // Bonus in the same cycle cancels the decrement
                        if (!bus.i_bonus_life) begin
                            w_count_nxt = r_count - CNT_W'(1);
                        end
                        w_grace_nxt = GRACE_W'(GRACE_FRAMES);
                        w_state_nxt = S_GRACE;
                    end else begin
                        w_count_nxt = '0;
                        w_state_nxt = S_DEAD;
                    end
                end else if (bus.i_bonus_life) begin
                    w_count_nxt = w_count_inc;
                end
            end

            S_GRACE: begin
                if (bus.i_bonus_life) begin
                    w_count_nxt = w_count_inc;
                end
                if (bus.i_frame_tick) begin
                    if (r_grace <= GRACE_W'(1)) begin
                        w_grace_nxt = '0;
                        w_state_nxt = S_PLAY;
                    end else begin
                        w_grace_nxt = r_grace - GRACE_W'(1);
                    end
                end
            end

            S_DEAD: begin
                w_count_nxt = '0;
                if (bus.i_new_game) begin
                    w_count_nxt = CNT_W'(INIT_LIVES);
                    w_state_nxt = S_PLAY;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_count     <= CNT_W'(INIT_LIVES);
            r_grace     <= '0;
            r_life_lost <= 1'b0;
            r_invuln    <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_count     <= w_count_nxt;
            r_grace     <= w_grace_nxt;
            r_life_lost <= w_life_lost_nxt;
            r_invuln    <= (w_state_nxt == S_GRACE);
            r_game_over <= (w_state_nxt == S_DEAD);
        end
    end

    assign bus.o_life_count = r_count;
    assign bus.o_invuln     = r_invuln;
    assign bus.o_life_lost  = r_life_lost;
    assign bus.o_game_over  = r_game_over;

endmodule

// File: tb/tb_life_manager.sv
// Testbench for life_manager: directed scenarios plus randomized run against a behavioural model.
module tb_life_manager;
    localparam int INIT_L = 3;
    localparam int MAX_L  = 5;
    localparam int GRACE  = 60;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Behavioural model: mode 0 idle, 1 playing, 2 invulnerable, 3 game over
    int m_mode  = 0;
    int m_lives = INIT_L;
    int m_grace = 0;
    int m_lost  = 0;

    life_manager_if u_if ();

    life_manager #(
        .INIT_LIVES   (INIT_L),
        .MAX_LIVES    (MAX_L),
        .GRACE_FRAMES (GRACE)
    ) u_dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (u_if)
    );

    always #5 clk = ~clk;

    // Model update for one clock with the given inputs
    task automatic model_step(input bit r, input bit ng, input bit ll, input bit bl, input bit ft);
        m_lost = 0;
        if (r) begin
            m_mode = 0; m_lives = INIT_L; m_grace = 0;
        end else if (m_mode == 0 || m_mode == 3) begin
            if (ng) begin m_lives = INIT_L; m_mode = 1; end
        end else if (m_mode == 1) begin
            if (ll) begin
                m_lost = 1;
                if (bl) begin m_mode = 2; m_grace = GRACE; end
                else if (m_lives == 1) begin m_lives = 0; m_mode = 3; end
                else begin m_lives = m_lives - 1; m_mode = 2; m_grace = GRACE; end
            end else if (bl) begin
                m_lives = (m_lives + 1 > MAX_L) ? MAX_L : m_lives + 1;
            end
        end else begin
            if (bl) m_lives = (m_lives + 1 > MAX_L) ? MAX_L : m_lives + 1;
            if (ft) begin
                m_grace = m_grace - 1;
                if (m_grace == 0) m_mode = 1;
            end
        end
    endtask

    // Drive one clock of inputs; outputs are stable #1 after the edge on return
    task automatic step(input bit r, input bit ng, input bit ll, input bit bl, input bit ft);
        rst = r;
        u_if.i_new_game = ng; u_if.i_life_loss = ll;
        u_if.i_bonus_life = bl; u_if.i_frame_tick = ft;
        @(posedge clk);
        #1;
        rst = 1'b0;
        u_if.i_new_game = 1'b0; u_if.i_life_loss = 1'b0;
        u_if.i_bonus_life = 1'b0; u_if.i_frame_tick = 1'b0;
        model_step(r, ng, ll, bl, ft);
    endtask

    // Tick frames until invulnerability ends; returns number of ticks
    task automatic expire_grace(output int ticks);
        ticks = 0;
        while (u_if.o_invuln === 1'b1 && ticks < 300) begin
            step(0, 0, 0, 0, 0);
            step(0, 0, 0, 0, 1);
            ticks++;
        end
        if (u_if.o_invuln !== 1'b0) begin
            n_tests++; n_fail++;
            $display("FAIL grace_timeout: invuln still %0b after %0d ticks", u_if.o_invuln, ticks);
        end
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, 0);
        n_tests++;
        if (u_if.o_life_count !== 3'(INIT_L) || u_if.o_invuln !== 1'b0 ||
            u_if.o_life_lost !== 1'b0 || u_if.o_game_over !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: count=%0d inv=%0b lost=%0b go=%0b expected 3/0/0/0",
                     u_if.o_life_count, u_if.o_invuln, u_if.o_life_lost, u_if.o_game_over);
        end
    endtask

    task automatic test_loss_grace();
        int ticks;
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        n_tests++;
        if (u_if.o_life_count !== 3'd2 || u_if.o_life_lost !== 1'b1 || u_if.o_invuln !== 1'b1) begin
            n_fail++;
            $display("FAIL loss: count=%0d lost=%0b inv=%0b expected 2/1/1",
                     u_if.o_life_count, u_if.o_life_lost, u_if.o_invuln);
        end
        step(0, 0, 0, 0, 0);
        n_tests++;
        if (u_if.o_life_lost !== 1'b0) begin
            n_fail++;
            $display("FAIL lost_pulse_width: lost=%0b expected 0", u_if.o_life_lost);
        end
        expire_grace(ticks);
        n_tests++;
        if (ticks != GRACE) begin
            n_fail++;
            $display("FAIL grace_len: ticks=%0d expected %0d", ticks, GRACE);
        end
        step(0, 0, 1, 0, 0);
        n_tests++;
        if (u_if.o_life_lost !== 1'b1 || u_if.o_life_count !== 3'd1) begin
            n_fail++;
            $display("FAIL back_in_play: lost=%0b count=%0d expected 1/1",
                     u_if.o_life_lost, u_if.o_life_count);
        end
    endtask

    task automatic test_grace_ignore();
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 0, 0);
            n_tests++;
            if (u_if.o_life_count !== 3'd2 || u_if.o_life_lost !== 1'b0 || u_if.o_invuln !== 1'b1) begin
                n_fail++;
                $display("FAIL grace_ignore[%0d]: count=%0d lost=%0b inv=%0b expected 2/0/1",
                         i, u_if.o_life_count, u_if.o_life_lost, u_if.o_invuln);
            end
        end
    endtask

    task automatic test_game_over();
        int ticks;
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 1, 0, 0);
            if (k < 2) expire_grace(ticks);
        end
        n_tests++;
        if (u_if.o_life_count !== 3'd0 || u_if.o_game_over !== 1'b1 ||
            u_if.o_life_lost !== 1'b1 || u_if.o_invuln !== 1'b0) begin
            n_fail++;
            $display("FAIL game_over: count=%0d go=%0b lost=%0b inv=%0b expected 0/1/1/0",
                     u_if.o_life_count, u_if.o_game_over, u_if.o_life_lost, u_if.o_invuln);
        end
        step(0, 0, 1, 1, 1);
        n_tests++;
        if (u_if.o_life_count !== 3'd0 || u_if.o_game_over !== 1'b1 || u_if.o_life_lost !== 1'b0) begin
            n_fail++;
            $display("FAIL dead_ignore: count=%0d go=%0b lost=%0b expected 0/1/0",
                     u_if.o_life_count, u_if.o_game_over, u_if.o_life_lost);
        end
        step(0, 1, 0, 0, 0);
        n_tests++;
        if (u_if.o_life_count !== 3'd3 || u_if.o_game_over !== 1'b0) begin
            n_fail++;
            $display("FAIL restart: count=%0d go=%0b expected 3/0",
                     u_if.o_life_count, u_if.o_game_over);
        end
    endtask

    task automatic test_bonus_sat();
        logic [2:0] exp_c;
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            step(0, 0, 0, 1, 0);
            exp_c = (INIT_L + i > MAX_L) ? 3'(MAX_L) : 3'(INIT_L + i);
            n_tests++;
            if (u_if.o_life_count !== exp_c) begin
                n_fail++;
                $display("FAIL bonus_sat[%0d]: count=%0d expected %0d", i, u_if.o_life_count, exp_c);
            end
        end
    endtask

    task automatic test_simultaneous();
        int ticks;
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        expire_grace(ticks);
        step(0, 0, 1, 0, 0);
        expire_grace(ticks);
        step(0, 0, 1, 1, 0);
        n_tests++;
        if (u_if.o_life_count !== 3'd1 || u_if.o_invuln !== 1'b1 ||
            u_if.o_game_over !== 1'b0 || u_if.o_life_lost !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_play: count=%0d inv=%0b go=%0b lost=%0b expected 1/1/0/1",
                     u_if.o_life_count, u_if.o_invuln, u_if.o_game_over, u_if.o_life_lost);
        end
        step(0, 0, 1, 1, 0);
        n_tests++;
        if (u_if.o_life_count !== 3'd2 || u_if.o_life_lost !== 1'b0 || u_if.o_invuln !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_grace: count=%0d lost=%0b inv=%0b expected 2/0/1",
                     u_if.o_life_count, u_if.o_life_lost, u_if.o_invuln);
        end
    endtask

    task automatic test_reset_mid_grace();
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(1, 1, 1, 1, 1);
        n_tests++;
        if (u_if.o_life_count !== 3'd3 || u_if.o_invuln !== 1'b0 ||
            u_if.o_life_lost !== 1'b0 || u_if.o_game_over !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_grace: count=%0d inv=%0b lost=%0b go=%0b expected 3/0/0/0",
                     u_if.o_life_count, u_if.o_invuln, u_if.o_life_lost, u_if.o_game_over);
        end
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        n_tests++;
        if (u_if.o_life_count !== 3'd3 || u_if.o_life_lost !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_ignore: count=%0d lost=%0b expected 3/0",
                     u_if.o_life_count, u_if.o_life_lost);
        end
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        n_tests++;
        if (u_if.o_life_count !== 3'd2 || u_if.o_life_lost !== 1'b1) begin
            n_fail++;
            $display("FAIL after_new_game: count=%0d lost=%0b expected 2/1",
                     u_if.o_life_count, u_if.o_life_lost);
        end
    endtask

    task automatic test_random();
        bit r, ng, ll, bl, ft;
        int bad = 0;
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 199) == 0);
            ng = ($urandom_range(0, 29) == 0);
            ll = ($urandom_range(0, 5) == 0);
            bl = ($urandom_range(0, 9) == 0);
            ft = ($urandom_range(0, 1) == 0);
            step(r, ng, ll, bl, ft);
            n_tests++;
            if (u_if.o_life_count !== 3'(m_lives) || u_if.o_invuln !== (m_mode == 2) ||
                u_if.o_game_over !== (m_mode == 3) || u_if.o_life_lost !== 1'(m_lost)) begin
                n_fail++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random[%0d]: count=%0d inv=%0b go=%0b lost=%0b expected %0d/%0b/%0b/%0d",
                             i, u_if.o_life_count, u_if.o_invuln, u_if.o_game_over, u_if.o_life_lost,
                             m_lives, (m_mode == 2), (m_mode == 3), m_lost);
            end
        end
    endtask

    initial begin
        u_if.i_new_game = 1'b0; u_if.i_life_loss = 1'b0;
        u_if.i_bonus_life = 1'b0; u_if.i_frame_tick = 1'b0;
        #2;
        test_reset();
        test_loss_grace();
        test_grace_ignore();
        test_game_over();
        test_bonus_sat();
        test_simultaneous();
        test_reset_mid_grace();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
